// File: rtl/ecc_pkg.sv
// Shared types for the ECC point-operation controller: GFAU op codes, register indices, microcode entries.
package ecc_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MULT = 2'd2,
    OP_DIV  = 2'd3
  } op_t;

  typedef enum logic [3:0] {
    X1 = 4'd0, Y1 = 4'd1, X2 = 4'd2, Y2 = 4'd3, A  = 4'd4, L  = 4'd5,
    T0 = 4'd6, T1 = 4'd7, T2 = 4'd8, T3 = 4'd9, T4 = 4'd10,
    X3 = 4'd11, Y3 = 4'd12
  } reg_t;

  typedef struct packed {
    op_t  op;
    reg_t src_a;
    reg_t src_b;
    reg_t dst;
  } ucode_entry_t;

  localparam logic [3:0] ADD_LEN = 4'd9;
  localparam logic [3:0] DBL_LEN = 4'd12;
  localparam int         NREGS   = 13;

endpackage

// File: rtl/ecc_ucode_rom.sv
// Microcode ROM: (double, pc) -> GFAU operation. The doubling table exists only when
// ECC_PT_DOUBLE_EN is defined.
module ecc_ucode_rom
  import ecc_pkg::*;
(
  input  logic         i_double,
  input  logic [3:0]   i_pc,
  output ucode_entry_t o_entry
);

  function automatic ucode_entry_t ent(op_t op, reg_t a, reg_t b, reg_t d);
    return ucode_entry_t'{op: op, src_a: a, src_b: b, dst: d};
  endfunction

`ifndef ECC_PT_DOUBLE_EN
  logic w_unused;
  assign w_unused = i_double;
`endif

  always_comb begin
    o_entry = ent(OP_ADD, X1, X1, T0);
`ifdef ECC_PT_DOUBLE_EN
    if (i_double) begin
      case (i_pc)
        4'd0:    o_entry = ent(OP_MULT, X1, X1, T0);
        4'd1:    o_entry = ent(OP_ADD,  T0, T0, T1);
        4'd2:    o_entry = ent(OP_ADD,  T1, T0, T1);
        4'd3:    o_entry = ent(OP_ADD,  T1, A,  T1);
        4'd4:    o_entry = ent(OP_ADD,  Y1, Y1, T2);
        4'd5:    o_entry = ent(OP_DIV,  T1, T2, L);
        4'd6:    o_entry = ent(OP_MULT, L,  L,  T3);
        4'd7:    o_entry = ent(OP_SUB,  T3, X1, T3);
        4'd8:    o_entry = ent(OP_SUB,  T3, X1, X3);
        4'd9:    o_entry = ent(OP_SUB,  X1, X3, T4);
        4'd10:   o_entry = ent(OP_MULT, L,  T4, T4);
        4'd11:   o_entry = ent(OP_SUB,  T4, Y1, Y3);
        default: o_entry = ent(OP_ADD,  X1, X1, T0);
      endcase
    end else
`endif
    begin
      case (i_pc)
        4'd0:    o_entry = ent(OP_SUB,  Y2, Y1, T0);
        4'd1:    o_entry = ent(OP_SUB,  X2, X1, T1);
        4'd2:    o_entry = ent(OP_DIV,  T0, T1, L);
        4'd3:    o_entry = ent(OP_MULT, L,  L,  T2);
        4'd4:    o_entry = ent(OP_SUB,  T2, X1, T2);
        4'd5:    o_entry = ent(OP_SUB,  T2, X2, X3);
        4'd6:    o_entry = ent(OP_SUB,  X1, X3, T3);
        4'd7:    o_entry = ent(OP_MULT, L,  T3, T3);
        4'd8:    o_entry = ent(OP_SUB,  T3, Y1, Y3);
        default: o_entry = ent(OP_ADD,  X1, X1, T0);
      endcase
    end
  end

endmodule

// File: rtl/ecc_point_ctrl.sv
// Sequences one EC point add (or double, with ECC_PT_DOUBLE_EN) over GF(p) by driving a single GFAU
// through a microcode table and a small register file.
module ecc_point_ctrl
  import ecc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_double,
  input  logic [WIDTH-1:0] i_x1,
  input  logic [WIDTH-1:0] i_y1,
  input  logic [WIDTH-1:0] i_x2,
  input  logic [WIDTH-1:0] i_y2,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_x3,
  output logic [WIDTH-1:0] o_y3,
  output logic             o_done,
  output logic             o_err,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  output logic [1:0]       o_op_sel,
  output logic             o_op_start,
  input  logic [WIDTH-1:0] i_op_result,
  input  logic             i_op_done
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t           r_state;
  logic [3:0]       r_pc;
  logic             r_dbl;
  reg_t             r_dst;
  logic [WIDTH-1:0] r_rf [NREGS];
  logic [WIDTH-1:0] r_x3, r_y3, r_op_a, r_op_b;
  logic [1:0]       r_op_sel;
  logic             r_done, r_err, r_busy, r_op_start;

  ucode_entry_t     w_ent;
  logic [3:0]       w_rom_pc, w_len;
  logic             w_last, w_chk_err;
  logic [WIDTH-1:0] w_opa, w_opb, w_res_x3, w_res_y3;

`ifndef ECC_PT_DOUBLE_EN
  logic w_unused;
  assign w_unused = i_double;
`endif

  // In WAIT the ROM already looks ahead to the next entry so its operands can be registered on i_op_done.
  assign w_rom_pc = (r_state == S_WAIT) ? (r_pc + 4'd1) : r_pc;
  assign w_len    = r_dbl ? DBL_LEN : ADD_LEN;
  assign w_last   = (r_pc == (w_len - 4'd1));

  ecc_ucode_rom u_rom (
    .i_double (r_dbl),
    .i_pc     (w_rom_pc),
    .o_entry  (w_ent)
  );

  // The result arriving this cycle is not in the register file yet, so forward it to the next op.
  always_comb begin
    w_opa = r_rf[w_ent.src_a];
    w_opb = r_rf[w_ent.src_b];
    if (r_state == S_WAIT) begin
      if (w_ent.src_a == r_dst) w_opa = i_op_result;
      if (w_ent.src_b == r_dst) w_opb = i_op_result;
    end
  end

  assign w_res_x3 = (r_dst == X3) ? i_op_result : r_rf[X3];
  assign w_res_y3 = (r_dst == Y3) ? i_op_result : r_rf[Y3];

`ifdef ECC_PT_DOUBLE_EN
  assign w_chk_err = r_dbl ? (r_rf[Y1] == '0) : (r_rf[X1] == r_rf[X2]);
`else
  assign w_chk_err = (r_rf[X1] == r_rf[X2]);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_dbl      <= 1'b0;
      r_dst      <= X1;
      r_x3       <= '0;
      r_y3       <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_sel   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_op_start <= 1'b0;
      for (int k = 0; k < NREGS; k++) r_rf[k] <= '0;
    end else begin
      r_op_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rf[X1] <= i_x1;
            r_rf[Y1] <= i_y1;
            r_rf[X2] <= i_x2;
            r_rf[Y2] <= i_y2;
            r_rf[A]  <= i_a;
`ifdef ECC_PT_DOUBLE_EN
            r_dbl    <= i_double;
`else
            r_dbl    <= 1'b0;
`endif
            r_pc     <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_chk_err) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_x3    <= '0;
            r_y3    <= '0;
            r_state <= S_FIN;
          end else begin
            r_err      <= 1'b0;
            r_op_a     <= w_opa;
            r_op_b     <= w_opb;
            r_op_sel   <= w_ent.op;
            r_dst      <= w_ent.dst;
            r_op_start <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_op_done) begin
            r_rf[r_dst] <= i_op_result;
            r_pc        <= r_pc + 4'd1;
            if (w_last) begin
              r_x3    <= w_res_x3;
              r_y3    <= w_res_y3;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_op_a     <= w_opa;
              r_op_b     <= w_opb;
              r_op_sel   <= w_ent.op;
              r_dst      <= w_ent.dst;
              r_op_start <= 1'b1;
              r_state    <= S_ISSUE;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_x3       = r_x3;
  assign o_y3       = r_y3;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_busy     = r_busy;
  assign o_op_a     = r_op_a;
  assign o_op_b     = r_op_b;
  assign o_op_sel   = r_op_sel;
  assign o_op_start = r_op_start;

endmodule

// File: tb/tb_ecc_point_ctrl.sv
// Directed bench for ecc_point_ctrl with a mod-97 GFAU model of programmable latency.
module tb_ecc_point_ctrl;
  localparam int W = 32;
  localparam int P = 97;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         i_start = 1'b0, i_double = 1'b0;
  logic [W-1:0] i_x1 = '0, i_y1 = '0, i_x2 = '0, i_y2 = '0, i_a = 32'd2;
  logic [W-1:0] o_x3, o_y3, o_op_a, o_op_b, i_op_result;
  logic         o_done, o_err, o_busy, o_op_start, i_op_done;
  logic [1:0]   o_op_sel;
  logic         spur = 1'b0;

  always #5 clk = ~clk;

  ecc_point_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_double(i_double),
    .i_x1(i_x1), .i_y1(i_y1), .i_x2(i_x2), .i_y2(i_y2), .i_a(i_a),
    .o_x3(o_x3), .o_y3(o_y3), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_op_sel(o_op_sel), .o_op_start(o_op_start),
    .i_op_result(i_op_result), .i_op_done(i_op_done)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gf(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ia, ib, inv;
    ia = longint'(a) % P;
    ib = longint'(b) % P;
    inv = 0;
    case (s)
      2'd0: return W'((ia + ib) % P);
      2'd1: return W'((ia - ib + P) % P);
      2'd2: return W'((ia * ib) % P);
      default: begin
        for (longint k = 1; k < P; k++) if ((ib * k) % P == 1) inv = k;
        return W'((ia * inv) % P);
      end
    endcase
  endfunction

  // GFAU model: latches operands on op_start, answers after lat cycles, watches operand stability.
  int           lat = 2;
  logic         m_done, m_pend;
  logic [W-1:0] m_res, m_a, m_b;
  logic [1:0]   m_sel;
  int           m_cnt;
  int           n_pulse = 0, n_unstable = 0, n_restart = 0;
  logic [1:0]   seq [0:255];

  assign i_op_done   = m_done | spur;
  assign i_op_result = m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0;
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_pend && (o_op_a !== m_a || o_op_b !== m_b || o_op_sel !== m_sel))
        n_unstable <= n_unstable + 1;
      if (o_op_start) begin
        if (m_pend) n_restart <= n_restart + 1;
        if (n_pulse < 256) seq[n_pulse] <= o_op_sel;
        n_pulse <= n_pulse + 1;
        m_a     <= o_op_a;
        m_b     <= o_op_b;
        m_sel   <= o_op_sel;
        m_res   <= gf(o_op_sel, o_op_a, o_op_b);
        m_pend  <= 1'b1;
        m_cnt   <= lat - 1;
        m_done  <= (lat == 1);
      end else if (m_pend) begin
        if (m_done) m_pend <= 1'b0;
        else begin
          if (m_cnt != 0) m_cnt <= m_cnt - 1;
          m_done <= (m_cnt == 1);
        end
      end
    end
  end

  logic [1:0] add_ops [0:8]  = '{2'd1, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
  logic [1:0] dbl_ops [0:11] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};

  task automatic start_op(input logic dbl, input int x1, input int y1, input int x2, input int y2);
    @(negedge clk);
    i_double = dbl;
    i_x1 = W'(x1); i_y1 = W'(y1); i_x2 = W'(x2); i_y2 = W'(y2);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!o_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!o_done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic dbl, input int x1, input int y1, input int x2,
                        input int y2, input int l, input int ex3, input int ey3, input logic eerr,
                        input int nops, input logic dseq);
    int cyc, p0;
    lat = l;
    p0 = n_pulse;
    start_op(dbl, x1, y1, x2, y2);
    wait_done(cyc);
    chk({tag, "_x3"}, o_x3, ex3);
    chk({tag, "_y3"}, o_y3, ey3);
    chk({tag, "_err"}, o_err, eerr);
    chk({tag, "_latency"}, cyc, 2 + nops * (1 + l));
    chk({tag, "_pulses"}, n_pulse - p0, nops);
    for (int i = 0; i < nops; i++)
      chk({tag, "_opsel"}, seq[p0 + i], dseq ? dbl_ops[i] : add_ops[i]);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, o_done, 1'b0);
    chk({tag, "_busy_drop"}, o_busy, 1'b0);
    chk({tag, "_x3_hold"}, o_x3, ex3);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_x3"}, o_x3, 0);
    chk({tag, "_y3"}, o_y3, 0);
    chk({tag, "_opstart"}, o_op_start, 0);
    chk({tag, "_opsel"}, o_op_sel, 0);
    chk({tag, "_opa"}, o_op_a, 0);
    chk({tag, "_opb"}, o_op_b, 0);
  endtask

  initial begin
    int cyc, p0, w;
    #2 rst_n = 1'b0;
    #20 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

`ifdef ECC_PT_DOUBLE_EN
    run_op("dbl", 1'b1, 3, 6, 0, 0, 2, 80, 10, 1'b0, 12, 1'b1);
    run_op("dbl_l1", 1'b1, 3, 6, 0, 0, 1, 80, 10, 1'b0, 12, 1'b1);
    run_op("dbl_l40", 1'b1, 3, 6, 0, 0, 40, 80, 10, 1'b0, 12, 1'b1);
    run_op("dbl_y0", 1'b1, 5, 0, 0, 0, 2, 0, 0, 1'b1, 0, 1'b1);
`else
    run_op("dbl_ign", 1'b1, 3, 6, 80, 10, 2, 80, 87, 1'b0, 9, 1'b0);
`endif
    run_op("add", 1'b0, 3, 6, 80, 10, 2, 80, 87, 1'b0, 9, 1'b0);
    run_op("add_neg_l1", 1'b0, 3, 6, 80, 87, 1, 3, 91, 1'b0, 9, 1'b0);
    run_op("add_neg_l40", 1'b0, 3, 6, 80, 87, 40, 3, 91, 1'b0, 9, 1'b0);
    run_op("add_inf", 1'b0, 3, 6, 3, 91, 2, 0, 0, 1'b1, 0, 1'b0);

    // Reset during the 5th WAIT.
    lat = 4;
    p0 = n_pulse;
    start_op(1'b0, 3, 6, 80, 10);
    w = 0;
    while (n_pulse < p0 + 5 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("rst_reach_wait5", n_pulse - p0, 5);
    rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", o_done, 1'b0);
    end
    rst_n = 1'b1;
    run_op("add_after_rst", 1'b0, 3, 6, 80, 10, 3, 80, 87, 1'b0, 9, 1'b0);

    // Start while busy, then a spurious op_done in IDLE.
    lat = 3;
    p0 = n_pulse;
    start_op(1'b0, 3, 6, 80, 10);
    repeat (4) @(negedge clk);
    i_x1 = 32'd5; i_x2 = 32'd5; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(cyc);
    chk("busy_start_x3", o_x3, 80);
    chk("busy_start_y3", o_y3, 87);
    chk("busy_start_err", o_err, 1'b0);
    chk("busy_start_pulses", n_pulse - p0, 9);
    repeat (2) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_x3", o_x3, 80);
    chk("spur_y3", o_y3, 87);
    chk("spur_busy", o_busy, 1'b0);
    chk("spur_done", o_done, 1'b0);
    chk("spur_pulses", n_pulse - p0, 9);

    chk("operands_stable", n_unstable, 0);
    chk("no_restart", n_restart, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
